// File: rtl/fp_norm_pkg.sv
// Shared FSM state encoding and default widths for the mantissa normalizer.
package fp_norm_pkg;

    localparam int MW_DEF = 8;
    localparam int EW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_t;

endpackage

// File: rtl/norm_shift_step.sv
// One normalization step: left shift with exponent decrement, or termination
// when the mantissa is zero, already normalized, or the exponent is exhausted.
module norm_shift_step #(
    parameter int MW = 8,
    parameter int EW = 4
) (
    input  logic [MW-1:0] m,
    input  logic [EW-1:0] e,
    output logic [MW-1:0] m_next,
    output logic [EW-1:0] e_next,
    output logic          done
);

    // Zero mantissa has no meaningful exponent, so it is forced to zero.
    always_comb begin
        m_next = m;
        e_next = e;
        done   = 1'b0;
        if (m == '0) begin
            e_next = '0;
            done   = 1'b1;
        end else if (m[MW-1] || (e == '0)) begin
            done = 1'b1;
        end else begin
            m_next = {m[MW-2:0], 1'b0};
            e_next = e - EW'(1);
        end
    end

endmodule

// File: rtl/normalize_mantissa.sv
// Post-adder mantissa normalizer: absorbs the carry-out on accept, then shifts
// left one bit per cycle until normalized, zero, or the exponent reaches zero.
// Optional ovf/uf status outputs are built when NORMALIZE_MANTISSA_FLAGS_EN is
// defined; the default build omits them.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready=1
// SHIFT | normalizing working registers one bit per cycle
// DONE  | result held on m_out/e_out until out_ready
module normalize_mantissa
    import fp_norm_pkg::*;
#(
    parameter int MW = MW_DEF,
    parameter int EW = EW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW:0]   sum_m,
    input  logic [EW-1:0] exp_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] m_out,
`ifdef NORMALIZE_MANTISSA_FLAGS_EN
    output logic [EW-1:0] e_out,
    output logic          ovf,
    output logic          uf
`else
    output logic [EW-1:0] e_out
`endif
);

    norm_state_t   state;
    logic [MW-1:0] m_q;
    logic [EW-1:0] e_q;
    logic [MW-1:0] step_m;
    logic [EW-1:0] step_e;
    logic          step_done;

    norm_shift_step #(
        .MW (MW),
        .EW (EW)
    ) u_step (
        .m      (m_q),
        .e      (e_q),
        .m_next (step_m),
        .e_next (step_e),
        .done   (step_done)
    );

    assign m_out = m_q;
    assign e_out = e_q;

    // Control FSM with registered handshake outputs and working registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            m_q       <= '0;
            e_q       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
`ifdef NORMALIZE_MANTISSA_FLAGS_EN
            ovf       <= 1'b0;
            uf        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state    <= SHIFT;
                        in_ready <= 1'b0;
`ifdef NORMALIZE_MANTISSA_FLAGS_EN
                        ovf      <= 1'b0;
                        uf       <= 1'b0;
`endif
                        if (sum_m[MW]) begin
                            if (&exp_in) begin
                                m_q <= '1;
                                e_q <= '1;
`ifdef NORMALIZE_MANTISSA_FLAGS_EN
                                ovf <= 1'b1;
`endif
                            end else begin
                                m_q <= sum_m[MW:1];
                                e_q <= exp_in + EW'(1);
                            end
                        end else begin
                            m_q <= sum_m[MW-1:0];
                            e_q <= exp_in;
                        end
                    end
                end
                SHIFT: begin
                    m_q <= step_m;
                    e_q <= step_e;
                    if (step_done) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
`ifdef NORMALIZE_MANTISSA_FLAGS_EN
                        uf        <= (m_q != '0) && !m_q[MW-1];
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_normalize_mantissa.sv
// Self-checking bench for normalize_mantissa (MW=8, EW=4), directed cases
// plus randomized operands against an arithmetic reference model.
module tb_normalize_mantissa;

    localparam int MW = 8;
    localparam int EW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [MW:0]   sum_m;
    logic [EW-1:0] exp_in;
    logic          out_valid;
    logic          out_ready;
    logic [MW-1:0] m_out;
    logic [EW-1:0] e_out;
`ifdef NORMALIZE_MANTISSA_FLAGS_EN
    logic          ovf;
    logic          uf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    normalize_mantissa #(.MW(MW), .EW(EW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_m     (sum_m),
        .exp_in    (exp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .m_out     (m_out),
`ifdef NORMALIZE_MANTISSA_FLAGS_EN
        .e_out     (e_out),
        .ovf       (ovf),
        .uf        (uf)
`else
        .e_out     (e_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference: value-level normalization, number of shifts is the leading
    // zero count limited by the available exponent.
    task automatic model(input int s, input int x, output int m, output int e,
                         output int lat, output int f_ovf, output int f_uf);
        int msb;
        int k;
        f_ovf = 0;
        f_uf  = 0;
        if (s >= 256) begin
            if (x == 15) begin
                m = 255; e = 15; f_ovf = 1;
            end else begin
                m = s / 2; e = x + 1;
            end
        end else begin
            m = s; e = x;
        end
        if (m == 0) begin
            e = 0; lat = 1;
        end else begin
            msb = 0;
            for (int i = 0; i < MW; i++) if (m >= (1 << i)) msb = i;
            k = (MW - 1) - msb;
            if (k > e) begin
                k = e;
                f_uf = 1;
            end
            m = (m << k) % 256;
            e = e - k;
            lat = k + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int s, input int x, input int hold, input string tag);
        int em, ee, elat, eovf, euf;
        int cyc;
        logic [MW-1:0] m_hold;
        logic [EW-1:0] e_hold;
        model(s, x, em, ee, elat, eovf, euf);
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({tag, ".in_ready_before"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        sum_m    = (MW+1)'(s);
        exp_in   = EW'(x);
        tick();
        in_valid = 1'b0;
        sum_m    = '0;
        exp_in   = '0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({tag, ".latency"}, 32'(cyc), 32'(elat));
        chk({tag, ".m_out"}, 32'(m_out), 32'(em));
        chk({tag, ".e_out"}, 32'(e_out), 32'(ee));
`ifdef NORMALIZE_MANTISSA_FLAGS_EN
        chk({tag, ".ovf"}, 32'(ovf), 32'(eovf));
        chk({tag, ".uf"}, 32'(uf), 32'(euf));
`endif
        m_hold = m_out;
        e_hold = e_out;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
            chk({tag, ".hold_m"}, 32'(m_out), 32'(m_hold));
            chk({tag, ".hold_e"}, 32'(e_out), 32'(e_hold));
        end
        chk({tag, ".done_in_ready"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int s, x;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum_m     = '0;
        exp_in    = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.m_out", 32'(m_out), 32'd0);
        chk("rst.e_out", 32'(e_out), 32'd0);
`ifdef NORMALIZE_MANTISSA_FLAGS_EN
        chk("rst.ovf", 32'(ovf), 32'd0);
        chk("rst.uf", 32'(uf), 32'd0);
`endif

        run_op(9'b0_0001_0110, 7, 0, "shift3");
        run_op(9'b1_0110_0101, 5, 0, "carry");
        run_op(9'b1_0000_0000, 15, 1, "sat");
        run_op(0, 9, 0, "zero");
        run_op(9'b0_0000_0100, 2, 0, "underflow");
        run_op(9'b0_1000_0000, 0, 5, "stall5");

        // Reset while an operand is still shifting.
        in_valid = 1'b1;
        sum_m    = 9'b0_0000_0001;
        exp_in   = 4'd9;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("midrst.in_shift", 32'(in_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.in_ready", 32'(in_ready), 32'd1);
        chk("midrst.m_out", 32'(m_out), 32'd0);
        chk("midrst.e_out", 32'(e_out), 32'd0);
        repeat (12) begin
            tick();
            chk("midrst.no_out", 32'(out_valid), 32'd0);
        end

        // Reset while holding a result in DONE.
        in_valid = 1'b1;
        sum_m    = 9'b0_1100_0000;
        exp_in   = 4'd3;
        tick();
        in_valid = 1'b0;
        tick();
        chk("donerst.valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("donerst.out_valid", 32'(out_valid), 32'd0);
        chk("donerst.in_ready", 32'(in_ready), 32'd1);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0:       s = int'($urandom_range(0, 15));
                1:       s = int'($urandom_range(256, 511));
                default: s = int'($urandom_range(0, 511));
            endcase
            x = int'($urandom_range(0, 15));
            run_op(s, x, int'($urandom_range(0, 2)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/normalize_mantissa.md
NORMALIZE_MANTISSA -- requirements
Module: normalize_mantissa

Interface
REQ-001 SHALL have parameter MW, default 8, mantissa width.
REQ-002 SHALL have parameter EW, default 4, exponent width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, operand present.
REQ-006 SHALL have port in_ready, output, 1, block can accept an operand.
REQ-007 SHALL have port sum_m, input, MW+1, raw adder mantissa; bit MW is the carry-out.
REQ-008 SHALL have port exp_in, input, EW, common exponent after alignment.
REQ-009 SHALL have port out_valid, output, 1, result present.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have port m_out, output, MW, normalized mantissa.
REQ-012 SHALL have port e_out, output, EW, adjusted exponent.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-014 SHALL accept an operand on the edge where in_valid&&in_ready, load working registers and enter SHIFT.
REQ-015 SHALL, at accept when sum_m[MW]=1 and exp_in is not all-ones, load m=sum_m[MW:1] and e=exp_in+1 (LSB dropped, truncation).
REQ-016 SHALL, at accept when sum_m[MW]=1 and exp_in is all-ones, saturate: load m=all-ones and e=all-ones.
REQ-017 SHALL, at accept when sum_m[MW]=0, load m=sum_m[MW-1:0] and e=exp_in.
REQ-018 SHALL, in SHIFT when m=0, force e=0 and go to DONE.
REQ-019 SHALL, in SHIFT when m[MW-1]=1 or e=0, go to DONE without shifting.
REQ-020 SHALL, in SHIFT otherwise, shift m left by one with zero fill, decrement e, and stay in SHIFT.
REQ-021 SHALL assert out_valid k+1 cycles after the accept edge, where k is the number of shifts performed (0..MW-1).
REQ-022 SHALL hold m_out, e_out and out_valid stable in DONE until out_ready=1, then return to IDLE on that edge.
REQ-023 SHALL NOT accept a new operand in the cycle in which DONE completes; the next accept is possible one cycle later, in IDLE.
REQ-024 SHALL drive m_out/e_out directly from the working registers.

Reset
REQ-025 SHALL, on rst=1 at any edge and in any state (including mid-SHIFT or DONE), go to IDLE and clear m, e and the flags; the in-flight operand is discarded.
REQ-026 SHALL have reset output values in_ready=1 (from the cycle after reset), out_valid=0, m_out=0, e_out=0.

Configuration
REQ-027 SHALL provide macro NORMALIZE_MANTISSA_FLAGS_EN; when defined, add outputs ovf (1 bit) and uf (1 bit), valid with out_valid and cleared on reset.
REQ-028 SHALL, when the macro is defined, set ovf=1 on the REQ-016 saturation case.
REQ-029 SHALL, when the macro is defined, set uf=1 when SHIFT exits with e=0 while m is nonzero and m[MW-1]=0.
REQ-030 SHALL, when the macro is undefined, omit the ovf/uf ports and flag logic, with no other behavioural change.

Structure
REQ-031 SHALL take the FSM state enum and the default MW/EW constants from shared package fp_norm_pkg.
REQ-032 SHALL place the single-step combinational shift/decrement/termination logic in sub-module norm_shift_step; the FSM and registers stay in the top level.

Verification (MW=8, EW=4)
REQ-033 SHALL cover: sum_m=9'b0_0001_0110, exp_in=7 -> m_out=8'b1011_0000, e_out=4, out_valid 4 cycles after accept.
REQ-034 SHALL cover: sum_m=9'b1_0110_0101, exp_in=5 -> m_out=8'b1011_0010, e_out=6, out_valid 1 cycle after accept.
REQ-035 SHALL cover: sum_m=9'b1_0000_0000, exp_in=15 -> m_out=8'hFF, e_out=15, ovf=1 when the macro is defined.
REQ-036 SHALL cover: sum_m=0, exp_in=9 -> m_out=0, e_out=0, out_valid 1 cycle after accept.
REQ-037 SHALL cover: sum_m=9'b0_0000_0100, exp_in=2 -> m_out=8'h10, e_out=0, uf=1 when the macro is defined, out_valid 3 cycles after accept.
REQ-038 SHALL cover: out_ready held low 5 cycles -> outputs stable and in_ready=0 throughout; rst pulsed mid-SHIFT -> IDLE, out_valid=0, in_ready=1 on the next cycle.
